// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the fetch PC, runs a one-in-flight instruction-bus
// handshake, applies trap/branch redirects and presents fetched words through a one-entry buffer.
module fetch_seq #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int unsigned ILEN     = 32
) (
   input  logic            clk,
   input  logic            reset,
   output logic            ireq_valid,
   output logic [63:0]     ireq_addr,
   input  logic            ireq_ready,
   input  logic            iresp_valid,
   input  logic [ILEN-1:0] iresp_data,
   input  logic            redirect_valid,
   input  logic [63:0]     redirect_pc,
   input  logic            trap_valid,
   input  logic [63:0]     trap_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [63:0]     out_pc,
   output logic [ILEN-1:0] out_instr,
   output logic            out_fault,
   output logic [63:0]     fetch_cnt,
   output logic [1:0]      dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never depends combinationally on ready, and the payload is held until the transfer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [63:0]     pc_q, pc_d;
   logic            drop_q, drop_d;
   logic [63:0]     buf_pc_q, buf_pc_d;
   logic [ILEN-1:0] buf_instr_q, buf_instr_d;
   logic            buf_fault_q, buf_fault_d;
   logic [63:0]     cnt_q, cnt_d;

   logic            redir;
   logic [63:0]     tgt;
   logic            misaligned;

   always_comb begin
      redir      = trap_valid | redirect_valid;
      tgt        = trap_valid ? trap_pc : redirect_pc;
      misaligned = (pc_q[1:0] != 2'b00);
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_d      = drop_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      buf_fault_d = buf_fault_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (redir) begin
               pc_d = tgt;
            end else begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (redir) begin
               pc_d = tgt;
               // The bus took the old address this edge; its response must be thrown away.
               if (!misaligned && ireq_ready) begin
                  drop_d  = 1'b1;
                  state_d = WAIT;
               end
            end else if (misaligned) begin
               buf_pc_d    = pc_q;
               buf_instr_d = '0;
               buf_fault_d = 1'b1;
               state_d     = HOLD;
            end else if (ireq_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (redir) begin
               pc_d = tgt;
               if (iresp_valid) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (iresp_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  buf_pc_d    = pc_q;
                  buf_instr_d = iresp_data;
                  buf_fault_d = 1'b0;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            // An entry taken on the same edge as a redirect still counts; decode squashes it.
            if (out_ready) begin
               cnt_d = cnt_q + 64'd1;
            end
            if (redir) begin
               pc_d    = tgt;
               state_d = REQ;
            end else if (out_ready) begin
               pc_d    = pc_q + 64'd4;
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         drop_q      <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= '0;
         buf_fault_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_q      <= drop_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         buf_fault_q <= buf_fault_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ireq_valid = (state_q == REQ) && !misaligned;
   assign ireq_addr  = pc_q;
   assign out_valid  = (state_q == HOLD);
   assign out_pc     = buf_pc_q;
   assign out_instr  = buf_instr_q;
   assign out_fault  = buf_fault_q;
   assign fetch_cnt  = cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Fetch sequencer. Owns the architectural fetch PC and drives the instruction-bus request/response handshake, with one request in flight at a time.
- Applies trap and branch redirects with fixed priority, and discards responses that a redirect has made stale.
- Presents each fetched instruction to decode through a one-entry valid/ready output buffer.
- Sits between the instruction bus and decode; replaces the free-running PC register in the fetch stage.

Parameters:
- RESET_PC, 64'h8000_0000, PC loaded on reset.
- ILEN, 32, instruction width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ireq_valid  out  1  instruction-bus request valid.
- ireq_addr  out  64  request address, equal to the current fetch PC.
- ireq_ready  in  1  bus accepts the address this cycle.
- iresp_valid  in  1  response data valid, one cycle per accepted request.
- iresp_data  in  ILEN  instruction word.
- redirect_valid  in  1  branch/jump redirect from execute.
- redirect_pc  in  64  redirect target.
- trap_valid  in  1  trap/return redirect from commit; takes priority over redirect_valid.
- trap_pc  in  64  trap target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts this cycle.
- out_pc  out  64  PC of the presented instruction.
- out_instr  out  ILEN  the presented instruction.
- out_fault  out  1  presented entry is a misaligned-fetch fault.
- fetch_cnt  out  64  count of entries accepted by decode.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, pc=RESET_PC, drop=0.
  - ireq_valid=0, ireq_addr=RESET_PC.
  - out_valid=0, out_pc=0, out_instr=0, out_fault=0, fetch_cnt=0.
  - Reset asserted mid-operation abandons any outstanding request. The bus owner must reset concurrently.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: moves to REQ on the first cycle after reset release.
- REQ:
  - ireq_valid=1, ireq_addr=pc.
  - If pc[1:0]!=0, no bus request is issued (ireq_valid=0). The block loads the output buffer with out_pc=pc, out_instr=0, out_fault=1, and moves to HOLD.
  - On ireq_ready, moves to WAIT.
- WAIT:
  - ireq_valid=0.
  - On iresp_valid with drop=0: output buffer gets pc/iresp_data with out_fault=0; moves to HOLD.
  - On iresp_valid with drop=1: response discarded, drop cleared, moves to REQ.
- HOLD:
  - out_valid=1; buffer contents stay stable until accepted.
  - On out_ready: pc<=pc+4 (64-bit wrap, no overflow check), fetch_cnt++, out_valid=0 next cycle, moves to REQ.
- Redirect target selection: tgt = trap_valid ? trap_pc : redirect_pc. The effective redirect is trap_valid|redirect_valid, applied on the edge it is sampled. In every case pc<=tgt.
  - IDLE: stays IDLE; pc<=tgt.
  - REQ without ireq_ready: remains REQ; ireq_addr=tgt next cycle. The bus allows the address to change before acceptance.
  - REQ with ireq_ready the same cycle: the accepted request is stale. Sets drop=1 and moves to WAIT.
  - WAIT without iresp_valid: sets drop=1.
  - WAIT with iresp_valid the same cycle: response discarded, moves to REQ, drop=0.
  - HOLD: buffer invalidated (out_valid=0 next cycle), moves to REQ.
  - HOLD with out_ready the same cycle: the entry counts as accepted (fetch_cnt++), and pc=tgt instead of pc+4. Decode squashes it by its own logic.
- Throughput: at most one request in flight. Best case is 3 cycles per instruction: REQ with ready, WAIT with response, HOLD with out_ready.
- ireq_valid, out_valid and out_fault are registered or state-decoded only. No combinational path from any input to any output.

Test Plan:
- Reset release, bus always ready, response 1 cycle after accept, out_ready=1:
  - First request addr 0x8000_0000.
  - out_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - fetch_cnt=3 after third accept.
- Redirect to 0x8000_0100 while in WAIT, response arrives 2 cycles later with data 0xDEAD_BEEF:
  - Data never appears on out_*.
  - Next ireq_addr=0x8000_0100.
- trap_valid (trap_pc=0x8000_0200) and redirect_valid (redirect_pc=0x8000_0300) in the same cycle:
  - Next request addr 0x8000_0200.
- Redirect to 0x8000_0102 (misaligned):
  - No ireq_valid.
  - out_valid=1, out_pc=0x8000_0102, out_fault=1, out_instr=0.
- out_ready held 0 for 5 cycles in HOLD:
  - out_pc/out_instr stable, ireq_valid=0 throughout.
  - On release, fetch_cnt increments by exactly 1.
- Reset asserted low while in WAIT:
  - Outputs return to reset values without waiting for a clock edge.
  - After release, first request addr=0x8000_0000.
